// File: rtl/add7_pkg.sv
// Shared types and widths for the 7-operand adder feeder.
package add7_pkg;

    localparam int unsigned NARROW_W = 10;
    localparam int unsigned WIDE_W   = 13;
    localparam int unsigned RESULT_W = 13;
    localparam int unsigned NUM_OPND = 7;
    localparam int unsigned CNT_W    = $clog2(NUM_OPND + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FIRE,
        ST_WAIT,
        ST_OUT
    } state_t;

    // Slots e and g (indices 4 and 6) are the only 13-bit operands.
    function automatic logic is_narrow(input cnt_t slot);
        return (slot != cnt_t'(4)) && (slot != cnt_t'(6));
    endfunction

endpackage

// File: rtl/add7_opnd_bank.sv
// Serial capture of the seven adder operands, with truncation of
// over-wide narrow operands and a sticky width-error flag per job.
module add7_opnd_bank
    import add7_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                accept,
    input  logic [WIDE_W-1:0]   in_data,
    output logic [NARROW_W-1:0] init_a,
    output logic [NARROW_W-1:0] init_b,
    output logic [NARROW_W-1:0] init_c,
    output logic [NARROW_W-1:0] init_d,
    output logic [WIDE_W-1:0]   init_e,
    output logic [NARROW_W-1:0] init_f,
    output logic [WIDE_W-1:0]   init_g,
    output logic                wid_err,
    output logic                last_c
);

    cnt_t cnt;

    assign last_c = (cnt == cnt_t'(NUM_OPND - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            wid_err <= 1'b0;
            init_a  <= '0;
            init_b  <= '0;
            init_c  <= '0;
            init_d  <= '0;
            init_e  <= '0;
            init_f  <= '0;
            init_g  <= '0;
        end else if (clr) begin
            cnt     <= '0;
            wid_err <= 1'b0;
        end else if (accept) begin
            cnt <= cnt_t'(cnt + 1'b1);
            if (is_narrow(cnt) && (in_data[WIDE_W-1:NARROW_W] != '0))
                wid_err <= 1'b1;
            case (cnt)
                cnt_t'(0): init_a <= in_data[NARROW_W-1:0];
                cnt_t'(1): init_b <= in_data[NARROW_W-1:0];
                cnt_t'(2): init_c <= in_data[NARROW_W-1:0];
                cnt_t'(3): init_d <= in_data[NARROW_W-1:0];
                cnt_t'(4): init_e <= in_data;
                cnt_t'(5): init_f <= in_data[NARROW_W-1:0];
                cnt_t'(6): init_g <= in_data;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/add7_feeder.sv
// Collects seven serial operands, fires the external 7-input adder once,
// waits (with timeout) for its sum and presents it on a valid/ready stream.
module add7_feeder
    import add7_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDE_W-1:0]   in_data,
    output logic                r_enable,
    output logic [NARROW_W-1:0] init_a,
    output logic [NARROW_W-1:0] init_b,
    output logic [NARROW_W-1:0] init_c,
    output logic [NARROW_W-1:0] init_d,
    output logic [WIDE_W-1:0]   init_e,
    output logic [NARROW_W-1:0] init_f,
    output logic [WIDE_W-1:0]   init_g,
    output logic                controlArr,
    input  logic                w_enable,
    input  logic [RESULT_W-1:0] result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data,
    output logic                out_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    logic [TMR_W-1:0]  wait_cnt;
    logic              tmo_err;
    logic              wid_err;
    logic              last_c;
    logic              accept_c;
    logic              xfer_c;

    assign accept_c   = in_valid && in_ready;
    assign xfer_c     = out_valid && out_ready;
    assign controlArr = 1'b0;

    add7_opnd_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (xfer_c),
        .accept  (accept_c),
        .in_data (in_data),
        .init_a  (init_a),
        .init_b  (init_b),
        .init_c  (init_c),
        .init_d  (init_d),
        .init_e  (init_e),
        .init_f  (init_f),
        .init_g  (init_g),
        .wid_err (wid_err),
        .last_c  (last_c)
    );

    // Job sequencer; w_enable is only looked at from the second WAIT cycle,
    // so a level left over from a previous (possibly reset) job is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            r_enable  <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
            wait_cnt  <= '0;
            tmo_err   <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        if (last_c) begin
                            state    <= ST_FIRE;
                            in_ready <= 1'b0;
                            r_enable <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_FIRE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if ((wait_cnt != '0) && w_enable) begin
                        out_data  <= result;
                        out_err   <= wid_err | tmo_err;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        out_data  <= '0;
                        tmo_err   <= 1'b1;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        wait_cnt <= TMR_W'(wait_cnt + 1'b1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        tmo_err   <= 1'b0;
                        wait_cnt  <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        out_err <= wid_err | tmo_err;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add7_feeder.sv
// Directed bench for add7_feeder with a behavioural 7-input adder and a
// scoreboard of expected result beats.
module tb_add7_feeder;

    localparam int unsigned TMO = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_data;
    logic        r_enable;
    logic [9:0]  init_a, init_b, init_c, init_d, init_f;
    logic [12:0] init_e, init_g;
    logic        control_arr;
    logic        w_en_dut;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic        out_err;

    // adder model state
    logic        w_enable = 1'b0;
    logic [12:0] result   = '0;
    logic [12:0] pend_sum = '0;
    int          pend_cnt = 0;
    logic        pending  = 1'b0;
    logic        w_stuck;
    logic        adder_on;

    typedef struct packed {
        logic [12:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] ops [7];
    int          tests   = 0;
    int          failed  = 0;
    int          cyc     = 0;
    int          ren_cnt = 0;

    always #5 clk = ~clk;

    assign w_en_dut = w_enable | w_stuck;

    add7_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .r_enable   (r_enable),
        .init_a     (init_a),
        .init_b     (init_b),
        .init_c     (init_c),
        .init_d     (init_d),
        .init_e     (init_e),
        .init_f     (init_f),
        .init_g     (init_g),
        .controlArr (control_arr),
        .w_enable   (w_en_dut),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_enable) ren_cnt <= ren_cnt + 1;
    end

    // Adder: samples operands on the r_enable edge, answers 8 cycles later.
    always @(posedge clk) begin
        if (r_enable && adder_on) begin
            pend_sum <= 13'(init_a) + 13'(init_b) + 13'(init_c) + 13'(init_d)
                      + init_e + 13'(init_f) + init_g;
            pend_cnt <= 7;
            pending  <= 1'b1;
            w_enable <= 1'b0;
        end else if (pending) begin
            if (pend_cnt == 0) begin
                w_enable <= 1'b1;
                result   <= pend_sum;
                pending  <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end else begin
            w_enable <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [12:0] a, input logic [12:0] b, input logic [12:0] c,
                           input logic [12:0] d, input logic [12:0] e, input logic [12:0] f,
                           input logic [12:0] g);
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
        ops[4] = e; ops[5] = f; ops[6] = g;
    endtask

    // Called and returns at a negedge; one operand per accepting cycle.
    task automatic send_ops(input int cnt);
        int n;
        for (int k = 0; k < cnt; k++) begin
            in_valid = 1'b1;
            in_data  = ops[k];
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("in_ready_accept", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_job(input int hold, input bit tmo);
        exp_t e;
        exp_t got;
        int   sum;
        logic err;
        int   r0;
        int   t0;
        int   n;
        sum = 0;
        err = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 4 || k == 6) begin
                sum += int'(ops[k]);
            end else begin
                sum += int'(ops[k] & 13'h03FF);
                if (ops[k][12:10] != 3'd0) err = 1'b1;
            end
        end
        e.data = tmo ? 13'd0 : 13'(sum % 8192);
        e.err  = err | tmo;
        sb.push_back(e);
        r0 = ren_cnt;
        send_ops(7);
        n = 0;
        while (!r_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r_enable_seen", 32'(r_enable), 32'd1);
        t0 = cyc;
        @(negedge clk);
        chk("r_enable_one_cycle", 32'(r_enable), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(cyc - t0), tmo ? 32'(TMO + 1) : 32'd10);
        got = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(got.data));
        chk("out_err", 32'(out_err), 32'(got.err));
        chk("init_a_held", 32'(init_a), 32'(ops[0][9:0]));
        chk("init_g_held", 32'(init_g), 32'(ops[6]));
        chk("in_ready_in_out", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(got.data));
            chk("hold_err", 32'(out_err), 32'(got.err));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        chk("r_enable_pulses", 32'(ren_cnt - r0), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        w_stuck   = 1'b0;
        adder_on  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_r_enable", 32'(r_enable), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_init_e", 32'(init_e), 32'd0);
        chk("control_arr", 32'(control_arr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // nominal sum 28
        set_ops(13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7);
        run_job(0, 1'b0);

        // max operands, sum wraps to 5113
        set_ops(13'd1023, 13'd1023, 13'd1023, 13'd1023, 13'd8191, 13'd1023, 13'd8191);
        run_job(0, 1'b0);

        // over-wide narrow operand a
        set_ops(13'h1400, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0);
        run_job(0, 1'b0);

        // adder silent -> timeout, then a clean job
        adder_on = 1'b0;
        set_ops(13'd9, 13'd8, 13'd7, 13'd6, 13'd5, 13'd4, 13'd3);
        run_job(0, 1'b1);
        adder_on = 1'b1;
        set_ops(13'd10, 13'd20, 13'd30, 13'd40, 13'd50, 13'd60, 13'd70);
        run_job(0, 1'b0);

        // consumer back-pressure for 5 cycles
        set_ops(13'd100, 13'd200, 13'd300, 13'd400, 13'd4000, 13'd500, 13'd6000);
        run_job(5, 1'b0);

        // reset mid-job with a stale w_enable held high
        set_ops(13'd11, 13'd12, 13'd13, 13'd0, 13'd0, 13'd0, 13'd0);
        send_ops(3);
        w_stuck = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_init_a", 32'(init_a), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || r_enable) seen++;
        end
        chk("stale_w_enable_ignored", 32'(seen), 32'd0);
        w_stuck = 1'b0;
        @(negedge clk);
        set_ops(13'd1000, 13'd2, 13'd3, 13'd4, 13'd5000, 13'd6, 13'd7);
        run_job(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
